// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, flush and FIFO ordering.
// Define PIPE_SKID_EN to add a second (skid) entry and register in_ready.
module pipe_stage_elastic #(
    parameter int unsigned      WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             r_m_v;
    logic [WIDTH-1:0] r_m_d;
    logic [1:0]       r_count;
    logic             w_m_v_nxt;
    logic [WIDTH-1:0] w_m_d_nxt;
    logic             w_acc;
    logic             w_rel;

    assign w_acc     = in_valid & in_ready;
    assign w_rel     = r_m_v & out_ready;
    assign out_valid = r_m_v;
    assign out_data  = r_m_d;
    assign count     = r_count;

`ifdef PIPE_SKID_EN
    logic             r_s_v;
    logic [WIDTH-1:0] r_s_d;
    logic             w_s_v_nxt;
    logic [WIDTH-1:0] w_s_d_nxt;

    // Registered ready: depends only on skid occupancy, never on out_ready.
    assign in_ready = ~r_s_v;

    always_comb begin
        w_m_v_nxt = r_m_v;
        w_m_d_nxt = r_m_d;
        w_s_v_nxt = r_s_v;
        w_s_d_nxt = r_s_d;
        if (flush) begin
            w_m_v_nxt = 1'b0;
            w_s_v_nxt = 1'b0;
        end else if (r_s_v) begin
            if (w_rel) begin
                w_m_d_nxt = r_s_d;
                w_s_v_nxt = 1'b0;
            end
        end else if (w_acc) begin
            if (!r_m_v || w_rel) begin
                w_m_v_nxt = 1'b1;
                w_m_d_nxt = in_data;
            end else begin
                w_s_v_nxt = 1'b1;
                w_s_d_nxt = in_data;
            end
        end else if (w_rel) begin
            w_m_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_v   <= 1'b0;
            r_m_d   <= RESET_VAL;
            r_s_v   <= 1'b0;
            r_s_d   <= RESET_VAL;
            r_count <= '0;
        end else begin
            r_m_v   <= w_m_v_nxt;
            r_m_d   <= w_m_d_nxt;
            r_s_v   <= w_s_v_nxt;
            r_s_d   <= w_s_d_nxt;
            r_count <= {1'b0, w_m_v_nxt} + {1'b0, w_s_v_nxt};
        end
    end
`else
    assign in_ready = ~r_m_v | out_ready;

    always_comb begin
        w_m_v_nxt = r_m_v;
        w_m_d_nxt = r_m_d;
        if (flush) begin
            w_m_v_nxt = 1'b0;
        end else if (w_acc) begin
            w_m_v_nxt = 1'b1;
            w_m_d_nxt = in_data;
        end else if (w_rel) begin
            w_m_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_v   <= 1'b0;
            r_m_d   <= RESET_VAL;
            r_count <= '0;
        end else begin
            r_m_v   <= w_m_v_nxt;
            r_m_d   <= w_m_d_nxt;
            r_count <= {1'b0, w_m_v_nxt};
        end
    end
`endif

endmodule
